cordic_ctrl: RTL

// - Sequencer for the iterative CORDIC datapath. Accepts one operation per valid/ready handshake,

---
 rtl/cordic_ctrl_pkg.sv | 21 ++
 rtl/cordic_ctrl_if.sv | 41 ++++
 rtl/cordic_ctrl_iter_cnt.sv | 32 +++
 rtl/cordic_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC sequencer slice.
//   cordic_state_e     : controller FSM states
//   cordic_mode_e      : rotation / vectoring selector
//   CORDIC_ITERATIONS  : default number of micro-rotations per operation
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ITER,
      DONE
   } cordic_state_e;

   typedef enum logic {
      CORDIC_ROTATION  = 1'b0,
      CORDIC_VECTORING = 1'b1
   } cordic_mode_e;

   localparam int CORDIC_ITERATIONS = 16;

endpackage

// File: rtl/cordic_ctrl_if.sv
// Stream/datapath signal bundle between the CORDIC top level, the sequencer
// and the datapath registers.
//   slave  : sequencer view (cordic_ctrl)
//   master : environment view (stream source/sink + datapath)
// Signals:
//   in_valid_i/in_ready_o   operation handshake, mode_i sampled on it
//   z_sign_i/y_sign_i       datapath sign bits used for the rotation direction
//   load_o                  one-cycle datapath load pulse
//   iter_en_o/iter_o/dir_o  micro-rotation enable, index and direction
//   mode_o                  latched mode of the operation in flight
//   busy_o                  high during LOAD and ITER
//   out_valid_o/out_ready_i result handshake
interface cordic_ctrl_if #(
   parameter int IterWidth = $clog2(cordic_pkg::CORDIC_ITERATIONS)
);

   logic                 in_valid_i;
   logic                 in_ready_o;
   logic                 mode_i;
   logic                 z_sign_i;
   logic                 y_sign_i;
   logic                 load_o;
   logic                 iter_en_o;
   logic [IterWidth-1:0] iter_o;
   logic                 dir_o;
   logic                 mode_o;
   logic                 busy_o;
   logic                 out_valid_o;
   logic                 out_ready_i;

   modport slave (
      input  in_valid_i, mode_i, z_sign_i, y_sign_i, out_ready_i,
      output in_ready_o, load_o, iter_en_o, iter_o, dir_o, mode_o, busy_o, out_valid_o
   );

   modport master (
      output in_valid_i, mode_i, z_sign_i, y_sign_i, out_ready_i,
      input  in_ready_o, load_o, iter_en_o, iter_o, dir_o, mode_o, busy_o, out_valid_o
   );

endinterface

// File: rtl/cordic_ctrl_iter_cnt.sv
// Modulo-Iterations iteration counter.
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset (count -> 0)
//   clr    synchronous clear (count -> 0)
//   en     advance the count by one, wrapping after Iterations-1
//   cnt    current count
//   tick   terminal count: en is high while cnt == Iterations-1
module cordic_iter_cnt #(
   parameter int Iterations = 16,
   parameter int IterWidth  = $clog2(Iterations)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr,
   input  logic                 en,
   output logic [IterWidth-1:0] cnt,
   output logic                 tick
);

   localparam logic [IterWidth-1:0] LastIdx = IterWidth'(Iterations - 1);

   assign tick = en & (cnt == LastIdx);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cordic_ctrl.sv
// Sequencer for the iterative CORDIC datapath. Accepts one operation per
// valid/ready handshake, pulses the datapath load, steps Iterations
// micro-rotations (index + direction), then holds the result valid until
// the consumer accepts it. A result accept can coincide with the next
// operation's handshake, so back-to-back operations have no idle bubble.
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset; forces every output to 0 while high
//   bus    cordic_ctrl_if.slave (see interface header for signal list)
module cordic_ctrl
   import cordic_pkg::*;
#(
   parameter int Iterations = CORDIC_ITERATIONS,
   parameter int IterWidth  = $clog2(Iterations)
) (
   input logic          clk_i,
   input logic          rst_i,
   cordic_ctrl_if.slave bus
);

   if ((Iterations < 2) || (Iterations > (1 << IterWidth))) begin : g_param_check
      $error("cordic_ctrl: Iterations must lie in 2..2**IterWidth");
   end

   cordic_state_e        state_q;
   cordic_state_e        state_d;
   cordic_mode_e         mode_q;
   logic [IterWidth-1:0] cnt;
   logic                 cnt_tick;
   logic                 cnt_clr;
   logic                 in_ready;
   logic                 load;
   logic                 iter_en;
   logic                 busy;
   logic                 out_valid;

   cordic_iter_cnt #(
      .Iterations (Iterations),
      .IterWidth  (IterWidth)
   ) u_iter_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (cnt_clr),
      .en    (iter_en),
      .cnt   (cnt),
      .tick  (cnt_tick)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mode_q  <= CORDIC_ROTATION;
      end else begin
         state_q <= state_d;
         if (in_ready && bus.in_valid_i) begin
            mode_q <= cordic_mode_e'(bus.mode_i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      load      = 1'b0;
      iter_en   = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      cnt_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid_i) state_d = LOAD;
         end
         LOAD: begin
            load    = 1'b1;
            busy    = 1'b1;
            cnt_clr = 1'b1;
            state_d = ITER;
         end
         ITER: begin
            iter_en = 1'b1;
            busy    = 1'b1;
            if (cnt_tick) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready_i) begin
               // Result consumed this cycle, so a new operation may be accepted too.
               in_ready = 1'b1;
               state_d  = bus.in_valid_i ? LOAD : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset blanks every output, even when the registered state is mid-operation.
      if (rst_i) begin
         in_ready  = 1'b0;
         load      = 1'b0;
         iter_en   = 1'b0;
         busy      = 1'b0;
         out_valid = 1'b0;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.load_o      = load;
   assign bus.iter_en_o   = iter_en;
   assign bus.busy_o      = busy;
   assign bus.out_valid_o = out_valid;
   assign bus.iter_o      = rst_i ? '0 : cnt;
   assign bus.mode_o      = ~rst_i & mode_q;
   // Rotation drives z toward 0 (add when z >= 0); vectoring drives y toward 0 (add when y < 0).
   assign bus.dir_o       = iter_en & ((mode_q == CORDIC_VECTORING) ? bus.y_sign_i : ~bus.z_sign_i);

endmodule
